// File: rtl/button_db_multi.sv
// button_db_multi: CHANNELS-wide pushbutton debouncer with a shared sample
// tick, 2-FF sync, hysteretic integrator, edge pulses and long-press pulse.
module button_db_multi #(
  parameter int CHANNELS = 4,
  parameter int CLK_DIV = 62500,
  parameter int CNT_MAX = 32,
  parameter int HIGH_TH = 28,
  parameter int LOW_TH = 3,
  parameter int LONG_TICKS = 1600,
  parameter logic [CHANNELS-1:0] INVERT = {CHANNELS{1'b0}}
) (
  input  logic                clk_in,
  input  logic                reset_n,
  input  logic                en,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic                tick
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(CNT_MAX);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] C_HI = CW'(HIGH_TH);
  localparam logic [CW-1:0] C_LO = CW'(LOW_TH);
  localparam logic [HW-1:0] H_TOP = HW'(LONG_TICKS);

  if (CHANNELS < 1 || CHANNELS > 32 || CLK_DIV < 2 ||
      LONG_TICKS < 1 || LOW_TH < 0 || LOW_TH >= HIGH_TH ||
      HIGH_TH > CNT_MAX - 1) begin : g_param_err
    $error("button_db_multi: illegal parameter set");
  end

  logic [DW-1:0]       div;
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic                step;

  // free-running sample divider, independent of en
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (div == DIV_TOP) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign tick = (div == DIV_TOP);
  assign step = tick & en;

  // two-flop synchroniser, polarity normalised before the first flop
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= button_in ^ INVERT;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic          db;
    logic          prs;
    logic          rls;
    logic          lng;
    logic          at_max;
    logic          rise;
    logic          fall;

    assign rise = !db && (cnt >= C_HI);
    assign fall = db && (cnt <= C_LO);

    // saturating integrator, moves one step per enabled tick
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (step) begin
        if (s2[i] && cnt != CNT_TOP) begin
          cnt <= cnt + 1'b1;
        end else if (!s2[i] && cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end
    end

    // hysteretic level with pulses aligned to the level change
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        db  <= 1'b0;
        prs <= 1'b0;
        rls <= 1'b0;
      end else begin
        db  <= rise | (db & !fall);
        prs <= rise;
        rls <= fall;
      end
    end

    // hold timer; long pulse fires once when it first reaches the top
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        hold   <= '0;
        at_max <= 1'b0;
        lng    <= 1'b0;
      end else begin
        if (!db) begin
          hold <= '0;
        end else if (step && hold != H_TOP) begin
          hold <= hold + 1'b1;
        end
        at_max <= (hold == H_TOP);
        lng    <= db && (hold == H_TOP) && !at_max && !fall;
      end
    end

    assign button_out[i]    = db;
    assign press_pulse[i]   = prs;
    assign release_pulse[i] = rls;
    assign long_pulse[i]    = lng;
  end

endmodule
